core_time_tracker: RTL and testbench
====================================

// Module: core_time_tracker
// PURPOSE
//  Producer side of the GVT path. Owns the dispatch of events to the NUM_CORE event cores.
//  Records the timestamp of the event each core is processing and drives the packed
//  core_times/core_vld vectors that the GVT min-reduction consumes.
//  Sits between the event-queue dispatcher and the cores. Registers every output, so the
//  downstream min-tree sees stable, glitch-free inputs.
// PARAMETERS
//  NUM_CORE  4           number of event cores; power of two, >= 2
//  TIME_WID  16          timestamp width, unsigned
//  CORE_WID  clog2(NUM_CORE)  core index width (localparam)
// PORTS
//  clk         in   1                  single clock, rising edge
//  rst_n       in   1                  asynchronous assert, active-low reset
//  disp_vld    in   1                  dispatcher offers an event
//  disp_time   in   TIME_WID           timestamp of the offered event
//  disp_rdy    out  1                  at least one core is idle
//  disp_core   out  CORE_WID           index of the core that takes the event
//  done_vld    in   NUM_CORE           1-cycle pulse per core: event finished
//  upd_vld     in   NUM_CORE           per-core request to lower the tracked time
//  upd_time    in   TIME_WID*NUM_CORE  packed candidate times; core i at [i*TIME_WID +: TIME_WID]
//  core_times  out  TIME_WID*NUM_CORE  tracked time per core, same packing
//  core_vld    out  NUM_CORE           core i is BUSY (its time counts toward GVT)
//  idle_cnt    out  clog2(NUM_CORE+1)  number of IDLE cores
//  err         out  1                  sticky protocol-error flag
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - All slots IDLE.
//   - core_vld=0, core_times=0, idle_cnt=NUM_CORE, err=0.
//   - disp_rdy=1 and disp_core=0 once reset is released.
//   - Reset mid-operation drops all in-flight tracking immediately.
//  Per-slot FSM: IDLE -> BUSY on accepted dispatch; BUSY -> IDLE on done_vld[i].
//  disp_rdy / disp_core
//   - Combinational from registered slot state only; no path from done_vld.
//   - disp_core = lowest-index IDLE slot.
//   - Don't-care when disp_rdy=0, but held at 0.
//  Dispatch
//   - Accepted when disp_vld & disp_rdy.
//   - Next cycle: core_vld[disp_core]=1 and core_times slot = disp_time. Latency is 1 cycle.
//   - At most one dispatch per cycle.
//  Completion
//   - done_vld[i] on a BUSY slot: next cycle core_vld[i]=0; core_times slot holds its last value.
//   - A slot freed in cycle N can be dispatched no earlier than cycle N+1.
//   - Dispatch and done in the same cycle touch different slots by construction; both take effect.
//  Lowering updates
//   - upd_vld[i] on a BUSY slot: time <= (upd_time_i < time) ? upd_time_i : time.
//   - Compare is unsigned, with no wrap handling.
//   - An update can never raise the tracked time.
//   - Several slots may update in one cycle, independently.
//  Priority within one slot: done_vld beats upd_vld; the update is discarded.
//  Errors (err sets next cycle; cleared only by reset)
//   - done_vld[i] or upd_vld[i] on an IDLE slot. The state is unchanged.
//  idle_cnt
//   - Registered; always equals the popcount of ~core_vld.
//   - The next value accounts for the dispatch and all dones of the current cycle.
//  Timestamps are unsigned TIME_WID bits; no arithmetic beyond compare and select.
// STRUCTURE
//  pdes_pkg (shared) holds:
//   - TIME_WID and NUM_CORE defaults.
//   - The slot-state encoding: IDLE=1'b0, BUSY=1'b1.
//   - time_min(a,b) unsigned-min function, also used by the GVT reduction.
//  One sub-module: idle_select, a lowest-index priority encoder.
//   - In: NUM_CORE idle mask. Out: any_idle and CORE_WID index.
//  Slot registers are written inline in a generate loop over cores.
// TESTING
//  1. Reset with NUM_CORE=4.
//     -> core_vld=0000, idle_cnt=4, disp_rdy=1, disp_core=0, err=0.
//  2. Dispatch times 10, 20, 30, 40 on consecutive cycles.
//     -> core_vld=1111, core_times={40,30,20,10}, disp_rdy=0, idle_cnt=0.
//  3. From step 2, pulse done_vld=0100 while disp_vld=1 with time 50.
//     -> next cycle slot 2 IDLE and no accept.
//     -> the cycle after, the event lands in slot 2 with time 50.
//  4. Slot 1 BUSY at time 20.
//     - upd_time 15 -> 15. Then upd_time 18 -> stays 15.
//     - done_vld[1] together with upd_vld[1] (time 5) -> slot idle; time stays 15.
//  5. Pulse done_vld[3] on an IDLE slot.
//     -> err=1 and stays set; no state change. Only rst_n clears it.
//  6. Assert rst_n=0 asynchronously mid-traffic, between clock edges.
//     -> outputs reach their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/pdes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pdes_pkg                                                                 |
// | Shared PDES definitions: default sizes, slot encoding, unsigned min.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pdes_pkg;

   localparam int c_def_num_core = 4;
   localparam int c_def_time_wid = 16;
   localparam int c_max_time_wid = 64;

   localparam logic c_slot_idle = 1'b0;
   localparam logic c_slot_busy = 1'b1;

   // Width-generic helper: callers zero-extend into 64 bits and truncate the result.
   function automatic logic [c_max_time_wid-1:0] time_min(
      input logic [c_max_time_wid-1:0] a,
      input logic [c_max_time_wid-1:0] b
   );
      return (a < b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/idle_select.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | idle_select                                                              |
// | Lowest-index priority encoder over the idle-slot mask.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module idle_select #(
   parameter int NUM_CORE = 4
) (
   input  logic [NUM_CORE-1:0]         idle_mask,
   output logic                        any_idle,
   output logic [$clog2(NUM_CORE)-1:0] idx
);

   localparam int c_idx_wid = $clog2(NUM_CORE);

   // Scan downward so the lowest idle index is the last one written.
   always_comb begin
      idx = '0;
      for (int i = NUM_CORE - 1; i >= 0; i--) begin
         if (idle_mask[i]) idx = c_idx_wid'(i);
      end
   end

   assign any_idle = |idle_mask;

endmodule
`default_nettype wire

// File: rtl/core_time_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_time_tracker                                                        |
// | Dispatches events to idle cores and tracks each busy core's timestamp.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module core_time_tracker
   import pdes_pkg::*;
#(
   parameter int NUM_CORE = c_def_num_core,
   parameter int TIME_WID = c_def_time_wid
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           disp_vld,
   input  logic [TIME_WID-1:0]            disp_time,
   output logic                           disp_rdy,
   output logic [$clog2(NUM_CORE)-1:0]    disp_core,
   input  logic [NUM_CORE-1:0]            done_vld,
   input  logic [NUM_CORE-1:0]            upd_vld,
   input  logic [TIME_WID*NUM_CORE-1:0]   upd_time,
   output logic [TIME_WID*NUM_CORE-1:0]   core_times,
   output logic [NUM_CORE-1:0]            core_vld,
   output logic [$clog2(NUM_CORE+1)-1:0]  idle_cnt,
   output logic                           err
);

   localparam int c_core_wid = $clog2(NUM_CORE);
   localparam int c_cnt_wid  = $clog2(NUM_CORE + 1);

   logic [NUM_CORE-1:0]   r_state;
   logic [NUM_CORE-1:0]   w_state_nxt;
   logic [NUM_CORE-1:0]   w_bad;
   logic [c_cnt_wid-1:0]  r_idle_cnt;
   logic [c_cnt_wid-1:0]  w_idle_nxt;
   logic                  r_err;
   logic                  w_any_idle;
   logic [c_core_wid-1:0] w_disp_core;
   logic                  w_accept;

   // Selection sees only registered state, keeping done_vld off the ready path.
   idle_select #(
      .NUM_CORE (NUM_CORE)
   ) u_idle_select (
      .idle_mask (~r_state),
      .any_idle  (w_any_idle),
      .idx       (w_disp_core)
   );

   assign w_accept = disp_vld & w_any_idle;

   for (genvar i = 0; i < NUM_CORE; i++) begin : g_slot
      logic [TIME_WID-1:0] r_time;
      logic [TIME_WID-1:0] w_cand;
      logic [TIME_WID-1:0] w_low;
      logic                w_take;
      logic                w_lower;

      assign w_cand  = upd_time[i*TIME_WID +: TIME_WID];
      assign w_low   = TIME_WID'(time_min(c_max_time_wid'(w_cand), c_max_time_wid'(r_time)));
      assign w_take  = w_accept && (w_disp_core == c_core_wid'(i));
      assign w_lower = (r_state[i] == c_slot_busy) && upd_vld[i] && !done_vld[i];

      assign w_state_nxt[i] = (r_state[i] == c_slot_busy)
                            ? (done_vld[i] ? c_slot_idle : c_slot_busy)
                            : (w_take      ? c_slot_busy : c_slot_idle);

      assign w_bad[i] = (r_state[i] == c_slot_idle) && (done_vld[i] || upd_vld[i]);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_time <= '0;
         end else if (w_take) begin
            r_time <= disp_time;
         end else if (w_lower) begin
            r_time <= w_low;
         end
      end

      assign core_times[i*TIME_WID +: TIME_WID] = r_time;
   end

   always_comb begin
      w_idle_nxt = '0;
      for (int k = 0; k < NUM_CORE; k++) begin
         if (w_state_nxt[k] == c_slot_idle) w_idle_nxt = w_idle_nxt + c_cnt_wid'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= '0;
         r_idle_cnt <= c_cnt_wid'(NUM_CORE);
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idle_cnt <= w_idle_nxt;
         r_err      <= r_err | (|w_bad);
      end
   end

   assign core_vld  = r_state;
   assign idle_cnt  = r_idle_cnt;
   assign err       = r_err;
   assign disp_rdy  = w_any_idle;
   assign disp_core = w_disp_core;

endmodule
`default_nettype wire

// File: tb/tb_core_time_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_core_time_tracker                                                     |
// | Scoreboard bench: randomized and directed traffic against a slot model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_core_time_tracker;

   localparam int NC = 4;
   localparam int TW = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              disp_vld = 1'b0;
   logic [TW-1:0]     disp_time = '0;
   logic              disp_rdy;
   logic [1:0]        disp_core;
   logic [NC-1:0]     done_vld = '0;
   logic [NC-1:0]     upd_vld = '0;
   logic [TW*NC-1:0]  upd_time = '0;
   logic [TW*NC-1:0]  core_times;
   logic [NC-1:0]     core_vld;
   logic [2:0]        idle_cnt;
   logic              err;

   core_time_tracker #(.NUM_CORE(NC), .TIME_WID(TW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .disp_vld   (disp_vld),
      .disp_time  (disp_time),
      .disp_rdy   (disp_rdy),
      .disp_core  (disp_core),
      .done_vld   (done_vld),
      .upd_vld    (upd_vld),
      .upd_time   (upd_time),
      .core_times (core_times),
      .core_vld   (core_vld),
      .idle_cnt   (idle_cnt),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NC-1:0]    vld;
      logic [TW*NC-1:0] times;
      logic [2:0]       icnt;
      logic             err;
      logic             rdy;
      logic [1:0]       core;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   // Behavioural model: one busy flag and one timestamp per core.
   bit            m_busy[NC];
   logic [TW-1:0] m_time[NC];
   bit            m_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model_expect();
      exp_t e;
      e.vld = '0; e.times = '0; e.icnt = '0; e.err = m_err; e.rdy = 1'b0; e.core = '0;
      for (int i = 0; i < NC; i++) begin
         e.vld[i] = m_busy[i];
         e.times[i*TW +: TW] = m_time[i];
         if (!m_busy[i]) e.icnt = e.icnt + 3'd1;
      end
      for (int i = NC - 1; i >= 0; i--) begin
         if (!m_busy[i]) begin
            e.rdy = 1'b1;
            e.core = 2'(i);
         end
      end
      return e;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin
         m_busy[i] = 1'b0;
         m_time[i] = '0;
      end
      m_err = 1'b0;
   endtask

   task automatic cycle(input bit dv, input logic [TW-1:0] dt, input logic [NC-1:0] dn,
                        input logic [NC-1:0] up, input logic [TW*NC-1:0] ut);
      int fi;
      @(negedge clk);
      disp_vld = dv; disp_time = dt; done_vld = dn; upd_vld = up; upd_time = ut;
      fi = -1;
      for (int i = 0; i < NC; i++) if (!m_busy[i] && fi < 0) fi = i;
      for (int i = 0; i < NC; i++) begin
         if (m_busy[i]) begin
            if (dn[i]) m_busy[i] = 1'b0;
            else if (up[i] && ut[i*TW +: TW] < m_time[i]) m_time[i] = ut[i*TW +: TW];
         end else if (dn[i] || up[i]) begin
            m_err = 1'b1;
         end
      end
      if (dv && fi >= 0) begin
         m_busy[fi] = 1'b1;
         m_time[fi] = dt;
      end
      sb.push_back(model_expect());
   endtask

   task automatic idle_cycle();
      cycle(1'b0, '0, '0, '0, '0);
   endtask

   // Asserted between clock edges; outputs are checked before the next edge.
   task automatic async_reset_check();
      #2;
      disp_vld = 1'b0; done_vld = '0; upd_vld = '0;
      rst_n = 1'b0;
      sb.delete();
      model_reset();
      #1;
      chk("rst_core_vld",   64'(core_vld),   64'(0));
      chk("rst_core_times", 64'(core_times), 64'(0));
      chk("rst_idle_cnt",   64'(idle_cnt),   64'(NC));
      chk("rst_err",        64'(err),        64'(0));
      chk("rst_disp_rdy",   64'(disp_rdy),   64'(1));
      chk("rst_disp_core",  64'(disp_core),  64'(0));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("core_vld",   64'(core_vld),   64'(e.vld));
            chk("core_times", 64'(core_times), 64'(e.times));
            chk("idle_cnt",   64'(idle_cnt),   64'(e.icnt));
            chk("err",        64'(err),        64'(e.err));
            chk("disp_rdy",   64'(disp_rdy),   64'(e.rdy));
            chk("disp_core",  64'(disp_core),  64'(e.core));
         end
      end
   end

   task automatic random_traffic(input int n);
      logic [NC-1:0]    busy_mask, dn, up;
      logic [TW*NC-1:0] ut;
      for (int c = 0; c < n; c++) begin
         busy_mask = '0;
         for (int i = 0; i < NC; i++) busy_mask[i] = m_busy[i];
         dn = busy_mask & NC'($urandom) & NC'($urandom);
         up = busy_mask & NC'($urandom);
         for (int i = 0; i < NC; i++) begin
            if ($urandom_range(1, 0) == 1) ut[i*TW +: TW] = TW'($urandom);
            else ut[i*TW +: TW] = m_time[i] - TW'($urandom_range(3, 0));
         end
         cycle(($urandom_range(2, 0) != 0), TW'($urandom), dn, up, ut);
      end
   endtask

   initial begin : stimulus
      int budget;
      model_reset();
      #1;
      async_reset_check();

      // Fill all four cores, then free slot 2 while a dispatch waits.
      cycle(1'b1, 16'd10, '0, '0, '0);
      cycle(1'b1, 16'd20, '0, '0, '0);
      cycle(1'b1, 16'd30, '0, '0, '0);
      cycle(1'b1, 16'd40, '0, '0, '0);
      cycle(1'b1, 16'd50, 4'b0100, '0, '0);
      cycle(1'b1, 16'd50, '0, '0, '0);
      idle_cycle();

      // Lowering on slot 1, then done beating a simultaneous update.
      @(negedge clk);
      async_reset_check();
      cycle(1'b1, 16'd10, '0, '0, '0);
      cycle(1'b1, 16'd20, '0, '0, '0);
      cycle(1'b0, '0, '0, 4'b0010, {16'd0, 16'd0, 16'd15, 16'd0});
      cycle(1'b0, '0, '0, 4'b0010, {16'd0, 16'd0, 16'd18, 16'd0});
      cycle(1'b0, '0, 4'b0010, 4'b0010, {16'd0, 16'd0, 16'd5, 16'd0});
      idle_cycle();

      // Done on an idle slot sets a sticky error.
      cycle(1'b0, '0, 4'b1000, '0, '0);
      idle_cycle();
      idle_cycle();

      random_traffic(300);

      // Reset mid-traffic, then resume.
      cycle(1'b1, 16'h1234, '0, '0, '0);
      async_reset_check();
      random_traffic(200);
      idle_cycle();

      budget = 20;
      while (sb.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
